// File: rtl/mc_ctrl_pkg.sv
// Shared state encodings, opcodes and control codes for the multi-cycle sequencer.
// Define MC_JUMP_EN to decode opcode 000010 (j) into S_JUMP; otherwise it is illegal.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_RESET    = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_MEMADR   = 4'd3,
        S_MEMRD    = 4'd4,
        S_MEMWB    = 4'd5,
        S_MEMWR    = 4'd6,
        S_RTYPE_EX = 4'd7,
        S_RTYPE_WB = 4'd8,
        S_BEQ_EX   = 4'd9,
        S_ADDI_EX  = 4'd10,
        S_ADDI_WB  = 4'd11,
        S_JUMP     = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } alu_op_t;

    typedef enum logic [1:0] {
        SRCB_BUSB      = 2'b00,
        SRCB_FOUR      = 2'b01,
        SRCB_SEXT      = 2'b10,
        SRCB_SEXT_SHFT = 2'b11
    } alu_src_b_t;

    typedef enum logic [1:0] {
        PCSRC_ALU    = 2'b00,
        PCSRC_ALUOUT = 2'b01,
        PCSRC_JUMP   = 2'b10
    } pc_source_t;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        alu_src_b_t alu_src_b;
        alu_op_t    alu_op;
        pc_source_t pc_source;
        logic       instr_done;
    } ctrl_t;

    // Execute-phase entry state for an opcode; S_FETCH marks an unsupported opcode.
    function automatic state_t dispatch_state(input logic [5:0] opcode);
        state_t nxt;
        case (opcode)
            OP_RTYPE:     nxt = S_RTYPE_EX;
            OP_LW, OP_SW: nxt = S_MEMADR;
            OP_BEQ:       nxt = S_BEQ_EX;
            OP_ADDI:      nxt = S_ADDI_EX;
`ifdef MC_JUMP_EN
            OP_J:         nxt = S_JUMP;
`else
            OP_J:         nxt = S_FETCH;
`endif
            default:      nxt = S_FETCH;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/mc_ctrl_fsm_if.sv
// Control/status bundle between the sequencer (master) and the execution datapath (slave).
interface mc_ctrl_fsm_if;
    logic [5:0] Opcode_6b;
    logic       Zero_1b;
    logic       MemReady_1b;
    logic       PCWrite_1b;
    logic       PCWriteCond_1b;
    logic       PCEn_1b;
    logic       IorD_1b;
    logic       MemRead_1b;
    logic       MemWrite_1b;
    logic       IRWrite_1b;
    logic       MemtoReg_1b;
    logic       RegDst_1b;
    logic       RegWrite_1b;
    logic       ALUSrcA_1b;
    logic [1:0] ALUSrcB_2b;
    logic [1:0] ALUOp_2b;
    logic [1:0] PCSource_2b;
    logic       Instr_Done_1b;
    logic       Illegal_Op_1b;
    logic [3:0] State_4b;

    modport master (
        input  Opcode_6b, Zero_1b, MemReady_1b,
        output PCWrite_1b, PCWriteCond_1b, PCEn_1b, IorD_1b, MemRead_1b, MemWrite_1b,
               IRWrite_1b, MemtoReg_1b, RegDst_1b, RegWrite_1b, ALUSrcA_1b, ALUSrcB_2b,
               ALUOp_2b, PCSource_2b, Instr_Done_1b, Illegal_Op_1b, State_4b
    );

    modport slave (
        output Opcode_6b, Zero_1b, MemReady_1b,
        input  PCWrite_1b, PCWriteCond_1b, PCEn_1b, IorD_1b, MemRead_1b, MemWrite_1b,
               IRWrite_1b, MemtoReg_1b, RegDst_1b, RegWrite_1b, ALUSrcA_1b, ALUSrcB_2b,
               ALUOp_2b, PCSource_2b, Instr_Done_1b, Illegal_Op_1b, State_4b
    );
endinterface

// File: rtl/mc_ctrl_out_decode.sv
// Combinational map from sequencer state (and MemReady) to every datapath control.
// S_JUMP outputs exist only when MC_JUMP_EN is defined.
module mc_ctrl_out_decode
    import mc_ctrl_pkg::*;
(
    input  state_t state,
    input  logic   mem_ready,
    output ctrl_t  ctrl
);

    always_comb begin
        // NOTE: default-assign every output first so no path through the case infers a latch.
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.ir_write  = mem_ready;
                ctrl.pc_write  = mem_ready;
            end
            S_DECODE:   ctrl.alu_src_b = SRCB_SEXT_SHFT;
            S_MEMADR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_SEXT;
            end
            S_MEMRD: begin
                ctrl.mem_read = 1'b1;
                ctrl.iord     = 1'b1;
            end
            S_MEMWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_MEMWR: begin
                ctrl.mem_write  = 1'b1;
                ctrl.iord       = 1'b1;
                ctrl.instr_done = mem_ready;
            end
            S_RTYPE_EX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_op    = ALUOP_FUNCT;
            end
            S_RTYPE_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.reg_dst    = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_BEQ_EX: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_op        = ALUOP_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PCSRC_ALUOUT;
                ctrl.instr_done    = 1'b1;
            end
            S_ADDI_EX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_SEXT;
            end
            S_ADDI_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.instr_done = 1'b1;
            end
`ifdef MC_JUMP_EN
            S_JUMP: begin
                ctrl.pc_write   = 1'b1;
                ctrl.pc_source  = PCSRC_JUMP;
                ctrl.instr_done = 1'b1;
            end
`endif
            default: ;
        endcase
    end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle control sequencer: state register, reset-hold counter and next-state logic.
// Optional j support is enabled by defining MC_JUMP_EN.
module mc_ctrl_fsm
    import mc_ctrl_pkg::*;
#(
    parameter int unsigned RESET_VECTOR_EN_CYCLES = 1
) (
    input logic          Clk_1b,
    input logic          Reset_n_1b,
    mc_ctrl_fsm_if.master bus
);

    localparam logic [3:0] HOLD_LAST = 4'(RESET_VECTOR_EN_CYCLES - 1);

    state_t     state;
    logic [3:0] hold_cnt;
    ctrl_t      ctrl;

    always_ff @(posedge Clk_1b or negedge Reset_n_1b) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (!Reset_n_1b) begin
            state    <= S_RESET;
            hold_cnt <= '0;
        end else begin
            case (state)
                S_RESET: begin
                    if (hold_cnt == HOLD_LAST) state <= S_FETCH;
                    else                       hold_cnt <= hold_cnt + 4'd1;
                end
                S_FETCH:    if (bus.MemReady_1b) state <= S_DECODE;
                S_DECODE:   state <= dispatch_state(bus.Opcode_6b);
                // Only lw and sw reach here, so anything but sw is a load.
                S_MEMADR:   state <= (bus.Opcode_6b == OP_SW) ? S_MEMWR : S_MEMRD;
                S_MEMRD:    if (bus.MemReady_1b) state <= S_MEMWB;
                S_MEMWR:    if (bus.MemReady_1b) state <= S_FETCH;
                S_RTYPE_EX: state <= S_RTYPE_WB;
                S_ADDI_EX:  state <= S_ADDI_WB;
                default:    state <= S_FETCH;
            endcase
        end
    end

    mc_ctrl_out_decode u_out_decode (
        .state     (state),
        .mem_ready (bus.MemReady_1b),
        .ctrl      (ctrl)
    );

    assign bus.PCWrite_1b     = ctrl.pc_write;
    assign bus.PCWriteCond_1b = ctrl.pc_write_cond;
    assign bus.PCEn_1b        = ctrl.pc_write | (ctrl.pc_write_cond & bus.Zero_1b);
    assign bus.IorD_1b        = ctrl.iord;
    assign bus.MemRead_1b     = ctrl.mem_read;
    assign bus.MemWrite_1b    = ctrl.mem_write;
    assign bus.IRWrite_1b     = ctrl.ir_write;
    assign bus.MemtoReg_1b    = ctrl.mem_to_reg;
    assign bus.RegDst_1b      = ctrl.reg_dst;
    assign bus.RegWrite_1b    = ctrl.reg_write;
    assign bus.ALUSrcA_1b     = ctrl.alu_src_a;
    assign bus.ALUSrcB_2b     = ctrl.alu_src_b;
    assign bus.ALUOp_2b       = ctrl.alu_op;
    assign bus.PCSource_2b    = ctrl.pc_source;
    assign bus.Instr_Done_1b  = ctrl.instr_done;
    assign bus.Illegal_Op_1b  = (state == S_DECODE) && (dispatch_state(bus.Opcode_6b) == S_FETCH);
    assign bus.State_4b       = state;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Self-checking bench for mc_ctrl_fsm: reset, per-instruction vector table, random program
// against a phase-sequence model, and asynchronous reset during a stalled store.
module tb_mc_ctrl_fsm;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mc_ctrl_fsm_if bus ();

    mc_ctrl_fsm #(.RESET_VECTOR_EN_CYCLES(1)) dut (
        .Clk_1b     (clk),
        .Reset_n_1b (rst_n),
        .bus        (bus)
    );

    typedef struct packed {
        logic [3:0] state;
        logic       pc_write, pc_write_cond, pc_en, iord, mem_read, mem_write, ir_write;
        logic       mem_to_reg, reg_dst, reg_write, alu_src_a;
        logic [1:0] alu_src_b, alu_op, pc_source;
        logic       instr_done, illegal;
    } obs_t;

    typedef struct packed {
        logic [3:0] st;
        logic       rdy;
    } cyc_t;

    typedef struct {
        logic [5:0] op;
        logic       zero;
        int         waits;
        int         exp_cycles;
        int         exp_done;
        int         exp_rw;
        int         exp_mw;
        int         exp_pcen;
        int         exp_ill;
        string      name;
    } vec_t;

    int   checks = 0;
    int   failures = 0;
    cyc_t exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    function automatic bit is_legal(input logic [5:0] op);
        case (op)
            6'h00, 6'h23, 6'h2b, 6'h04, 6'h08: return 1'b1;
`ifdef MC_JUMP_EN
            6'h02: return 1'b1;
`endif
            default: return 1'b0;
        endcase
    endfunction

    function automatic obs_t get_obs();
        obs_t o;
        o.state         = bus.State_4b;
        o.pc_write      = bus.PCWrite_1b;
        o.pc_write_cond = bus.PCWriteCond_1b;
        o.pc_en         = bus.PCEn_1b;
        o.iord          = bus.IorD_1b;
        o.mem_read      = bus.MemRead_1b;
        o.mem_write     = bus.MemWrite_1b;
        o.ir_write      = bus.IRWrite_1b;
        o.mem_to_reg    = bus.MemtoReg_1b;
        o.reg_dst       = bus.RegDst_1b;
        o.reg_write     = bus.RegWrite_1b;
        o.alu_src_a     = bus.ALUSrcA_1b;
        o.alu_src_b     = bus.ALUSrcB_2b;
        o.alu_op        = bus.ALUOp_2b;
        o.pc_source     = bus.PCSource_2b;
        o.instr_done    = bus.Instr_Done_1b;
        o.illegal       = bus.Illegal_Op_1b;
        return o;
    endfunction

    // Output table of the control phases, keyed by phase number.
    function automatic obs_t exp_obs(input logic [3:0] st, input logic rdy, input logic z,
                                     input logic [5:0] op);
        obs_t o;
        o = '0;
        o.state = st;
        case (st)
            4'd1:  begin o.mem_read = 1; o.alu_src_b = 2'b01; o.ir_write = rdy; o.pc_write = rdy; end
            4'd2:  begin o.alu_src_b = 2'b11; o.illegal = !is_legal(op); end
            4'd3:  begin o.alu_src_a = 1; o.alu_src_b = 2'b10; end
            4'd4:  begin o.mem_read = 1; o.iord = 1; end
            4'd5:  begin o.reg_write = 1; o.mem_to_reg = 1; o.instr_done = 1; end
            4'd6:  begin o.mem_write = 1; o.iord = 1; o.instr_done = rdy; end
            4'd7:  begin o.alu_src_a = 1; o.alu_op = 2'b10; end
            4'd8:  begin o.reg_write = 1; o.reg_dst = 1; o.instr_done = 1; end
            4'd9:  begin o.alu_src_a = 1; o.alu_op = 2'b01; o.pc_write_cond = 1;
                         o.pc_source = 2'b01; o.instr_done = 1; end
            4'd10: begin o.alu_src_a = 1; o.alu_src_b = 2'b10; end
            4'd11: begin o.reg_write = 1; o.instr_done = 1; end
`ifdef MC_JUMP_EN
            4'd12: begin o.pc_write = 1; o.pc_source = 2'b10; o.instr_done = 1; end
`endif
            default: ;
        endcase
        o.pc_en = o.pc_write | (o.pc_write_cond & z);
        return o;
    endfunction

    function automatic void push(input logic [3:0] st, input logic rdy);
        exp_q.push_back(cyc_t'{st, rdy});
    endfunction

    // Phase sequence of one instruction: fetch with wf stalls, decode, then its execute path.
    function automatic void build_expected(input logic [5:0] op, input int wf, input int wm);
        for (int i = 0; i < wf; i++) push(4'd1, 1'b0);
        push(4'd1, 1'b1);
        push(4'd2, 1'($urandom));
        case (op)
            6'h00: begin push(4'd7, 1'($urandom)); push(4'd8, 1'($urandom)); end
            6'h23: begin
                push(4'd3, 1'($urandom));
                for (int i = 0; i < wm; i++) push(4'd4, 1'b0);
                push(4'd4, 1'b1);
                push(4'd5, 1'($urandom));
            end
            6'h2b: begin
                push(4'd3, 1'($urandom));
                for (int i = 0; i < wm; i++) push(4'd6, 1'b0);
                push(4'd6, 1'b1);
            end
            6'h04: push(4'd9, 1'($urandom));
            6'h08: begin push(4'd10, 1'($urandom)); push(4'd11, 1'($urandom)); end
`ifdef MC_JUMP_EN
            6'h02: push(4'd12, 1'($urandom));
`endif
            default: ;
        endcase
    endfunction

    task automatic cycle(input string name, input logic rdy, input logic z, input logic [5:0] op,
                         input logic [3:0] st);
        bus.MemReady_1b = rdy;
        bus.Zero_1b     = z;
        bus.Opcode_6b   = op;
        @(negedge clk);
        check(name, {9'd0, get_obs()}, {9'd0, exp_obs(st, rdy, z, op)});
        @(posedge clk);
        #1;
    endtask

    // Runs one instruction from S_FETCH, stalling memory states v.waits times, and tallies strobes.
    task automatic run_vec(input vec_t v);
        int  c = 0, waits = v.waits, done_at = 0, rw = 0, mw = 0, pcen = 0, ill = 0;
        bit  finished = 0;
        logic [3:0] st;
        logic rdy;
        bus.Opcode_6b = v.op;
        bus.Zero_1b   = v.zero;
        while (!finished && c < 40) begin
            st = bus.State_4b;
            if (c > 0 && st == 4'd1) begin
                finished = 1;
            end else begin
                c++;
                rdy = ((st == 4'd4 || st == 4'd6) && waits > 0) ? 1'b0 : 1'b1;
                if (!rdy) waits--;
                bus.MemReady_1b = rdy;
                @(negedge clk);
                if (bus.Instr_Done_1b && done_at == 0) done_at = c;
                rw   += int'(bus.RegWrite_1b);
                mw   += int'(bus.MemWrite_1b);
                pcen += int'(bus.PCEn_1b);
                ill  += int'(bus.Illegal_Op_1b);
                @(posedge clk);
                #1;
            end
        end
        check({v.name, "_timeout"}, 32'(finished), 32'd1);
        check({v.name, "_cycles"},  c,       v.exp_cycles);
        check({v.name, "_done_at"}, done_at, v.exp_done);
        check({v.name, "_regwr"},   rw,      v.exp_rw);
        check({v.name, "_memwr"},   mw,      v.exp_mw);
        check({v.name, "_pcen"},    pcen,    v.exp_pcen);
        check({v.name, "_illegal"}, ill,     v.exp_ill);
    endtask

    initial begin
        vec_t       vecs[$];
        cyc_t       rec;
        logic [5:0] rop;
        logic [5:0] fop;
        int         wf, wm;

        vecs.push_back('{6'h00, 1'b0, 0, 4, 4, 1, 0, 1, 0, "rtype"});
        vecs.push_back('{6'h23, 1'b0, 0, 5, 5, 1, 0, 1, 0, "lw_w0"});
        vecs.push_back('{6'h23, 1'b0, 2, 7, 7, 1, 0, 1, 0, "lw_w2"});
        vecs.push_back('{6'h2b, 1'b0, 0, 4, 4, 0, 1, 1, 0, "sw_w0"});
        vecs.push_back('{6'h2b, 1'b0, 3, 7, 7, 0, 4, 1, 0, "sw_w3"});
        vecs.push_back('{6'h04, 1'b1, 0, 3, 3, 0, 0, 2, 0, "beq_taken"});
        vecs.push_back('{6'h04, 1'b0, 0, 3, 3, 0, 0, 1, 0, "beq_not"});
        vecs.push_back('{6'h08, 1'b0, 0, 4, 4, 1, 0, 1, 0, "addi"});
        vecs.push_back('{6'h3f, 1'b1, 0, 2, 0, 0, 0, 1, 1, "illegal"});
`ifdef MC_JUMP_EN
        vecs.push_back('{6'h02, 1'b1, 0, 3, 3, 0, 0, 2, 0, "jump"});
`else
        vecs.push_back('{6'h02, 1'b1, 0, 2, 0, 0, 0, 1, 1, "jump_illegal"});
`endif

        bus.Opcode_6b   = 6'h00;
        bus.Zero_1b     = 1'b1;
        bus.MemReady_1b = 1'b1;

        // Reset held across edges, then release between edges.
        repeat (3) begin
            @(posedge clk);
            #1;
            check("reset_hold", {9'd0, get_obs()}, {9'd0, exp_obs(4'd0, 1'b1, 1'b1, 6'h00)});
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("reset_release", {9'd0, get_obs()}, {9'd0, exp_obs(4'd0, 1'b1, 1'b1, 6'h00)});
        @(posedge clk);
        #1;

        cycle("rtype_fetch",  1'b1, 1'b0, 6'h00, 4'd1);
        cycle("rtype_decode", 1'b1, 1'b0, 6'h00, 4'd2);
        cycle("rtype_ex",     1'b1, 1'b0, 6'h00, 4'd7);
        cycle("rtype_wb",     1'b1, 1'b0, 6'h00, 4'd8);

        foreach (vecs[i]) run_vec(vecs[i]);

        // Random program checked cycle by cycle against the phase-sequence model.
        for (int n = 0; n < 200; n++) begin
            case ($urandom_range(0, 7))
                0: rop = 6'h00;
                1: rop = 6'h23;
                2: rop = 6'h2b;
                3: rop = 6'h04;
                4: rop = 6'h08;
                5: rop = 6'h02;
                default: rop = 6'($urandom);
            endcase
            wf = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0;
            wm = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0;
            build_expected(rop, wf, wm);
            while (exp_q.size() > 0) begin
                rec = exp_q.pop_front();
                fop = (rec.st == 4'd1) ? 6'($urandom) : rop;
                cycle($sformatf("rand%0d_op%h", n, rop), rec.rdy, 1'($urandom), fop, rec.st);
            end
        end

        // Store stalled in S_MEMWR, then reset asserted between edges.
        cycle("sw_fetch",  1'b1, 1'b0, 6'h2b, 4'd1);
        cycle("sw_decode", 1'b1, 1'b0, 6'h2b, 4'd2);
        cycle("sw_memadr", 1'b1, 1'b0, 6'h2b, 4'd3);
        cycle("sw_wait",   1'b0, 1'b0, 6'h2b, 4'd6);
        #1;
        check("sw_stall", {9'd0, get_obs()}, {9'd0, exp_obs(4'd6, 1'b0, 1'b0, 6'h2b)});
        rst_n = 1'b0;
        #1;
        check("reset_async", {9'd0, get_obs()}, {9'd0, exp_obs(4'd0, 1'b0, 1'b0, 6'h2b)});
        @(negedge clk);
        rst_n = 1'b1;
        bus.MemReady_1b = 1'b1;
        #1;
        check("restart_reset", {9'd0, get_obs()}, {9'd0, exp_obs(4'd0, 1'b1, 1'b0, 6'h2b)});
        @(posedge clk);
        #1;
        cycle("restart_fetch", 1'b1, 1'b0, 6'h00, 4'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mc_ctrl_fsm.md
Name: mc_ctrl_fsm

Overview:
- Multi-cycle control sequencer for the existing execution datapath (sign-extender, branch adder, ALUSrc mux, ALU control, ALU).
- Time-shares the single ALU across fetch, decode, execute, memory and writeback phases of R-type, lw, sw, beq and addi.
- Drives all datapath enables and mux selects.
- Stalls on a memory-ready handshake.

Parameters:
- RESET_VECTOR_EN_CYCLES, 1, number of cycles spent in S_RESET after reset release before the first fetch (range 1-15).

Ports:
- Clk_1b  input  1  system clock, rising edge.
- Reset_n_1b  input  1  asynchronous, active-low reset.
- Opcode_6b  input  6  IR[31:26], valid from S_DECODE onward.
- Zero_1b  input  1  ALU zero flag.
- MemReady_1b  input  1  memory completes the current access this cycle.
- PCWrite_1b  output  1  unconditional PC update.
- PCWriteCond_1b  output  1  PC update if Zero_1b.
- PCEn_1b  output  1  PCWrite_1b | (PCWriteCond_1b & Zero_1b).
- IorD_1b  output  1  memory address select: 0=PC, 1=ALUOut.
- MemRead_1b  output  1  memory read request.
- MemWrite_1b  output  1  memory write request.
- IRWrite_1b  output  1  instruction register load.
- MemtoReg_1b  output  1  writeback data: 0=ALUOut, 1=MDR.
- RegDst_1b  output  1  destination register: 0=rt, 1=rd.
- RegWrite_1b  output  1  register file write.
- ALUSrcA_1b  output  1  ALU A input: 0=PC, 1=BusA.
- ALUSrcB_2b  output  2  ALU B input: 00=BusB, 01=const 4, 10=SExtn, 11=SExtnShft.
- ALUOp_2b  output  2  00=add, 01=sub, 10=funct; feeds ALU_Ctrl_Unit.
- PCSource_2b  output  2  PC source: 00=ALU result, 01=ALUOut, 10=jump target.
- Instr_Done_1b  output  1  pulses in the retiring cycle of an instruction.
- Illegal_Op_1b  output  1  pulses in S_DECODE when the opcode is unsupported.
- State_4b  output  4  current state, for debug.

Behaviour:
- Reset: async assert forces S_RESET (0). In S_RESET every output is 0. The block stays in S_RESET for RESET_VECTOR_EN_CYCLES clock edges after release, then enters S_FETCH. Reset mid-instruction aborts the instruction immediately and suppresses any pending write.
- Outputs are a combinational decode of the state register. Memory-gated strobes are additionally ANDed with MemReady_1b. Any signal not listed for a state is 0.
- States, encoding, outputs and next state:
  - S_FETCH(1): MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00, IRWrite=PCWrite=MemReady. Holds while MemReady=0; on MemReady=1 goes to S_DECODE.
  - S_DECODE(2): ALUSrcA=0, ALUSrcB=11, ALUOp=00 (branch target precompute). Next state by opcode:
    - 000000 -> S_RTYPE_EX.
    - 100011 or 101011 -> S_MEMADR.
    - 000100 -> S_BEQ_EX.
    - 001000 -> S_ADDI_EX.
    - Any other opcode -> S_FETCH with Illegal_Op_1b=1. No register or memory write occurs.
  - S_MEMADR(3): ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next: lw -> S_MEMRD, sw -> S_MEMWR. The opcode is re-sampled here; the IR is stable.
  - S_MEMRD(4): MemRead=1, IorD=1. Holds until MemReady, then S_MEMWB.
  - S_MEMWB(5): RegWrite=1, MemtoReg=1, RegDst=0, Instr_Done=1. Next: S_FETCH.
  - S_MEMWR(6): MemWrite=1, IorD=1. Instr_Done=MemReady. Holds until MemReady, then S_FETCH.
  - S_RTYPE_EX(7): ALUSrcA=1, ALUSrcB=00, ALUOp=10. Next: S_RTYPE_WB.
  - S_RTYPE_WB(8): RegWrite=1, RegDst=1, MemtoReg=0, Instr_Done=1. Next: S_FETCH.
  - S_BEQ_EX(9): ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01, Instr_Done=1. Next: S_FETCH.
  - S_ADDI_EX(10): ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next: S_ADDI_WB.
  - S_ADDI_WB(11): RegWrite=1, RegDst=0, MemtoReg=0, Instr_Done=1. Next: S_FETCH.
  - Unused encodings: next state S_FETCH, all outputs 0.
- Latency with zero wait states (cycles from S_FETCH entry to retirement): lw 5, sw 4, R-type 4, addi 4, beq 3.
- Each cycle MemReady_1b stays 0 in S_FETCH, S_MEMRD or S_MEMWR adds exactly one cycle. Requests stay asserted and stable while waiting.
- MemRead_1b and MemWrite_1b are never high in the same cycle.
- RegWrite_1b and PCEn_1b are never high in S_RESET.

Optional Feature:
- MC_JUMP_EN defined: opcode 000010 in S_DECODE goes to S_JUMP(12).
  - S_JUMP outputs: PCWrite=1, PCSource=10, Instr_Done=1. Next: S_FETCH.
  - j latency is 3 cycles.
- MC_JUMP_EN undefined: 000010 is illegal (Illegal_Op_1b pulse, return to S_FETCH). Encoding 12 falls under the unused-encoding rule.

Decomposition:
- Package mc_ctrl_pkg holds:
  - state encodings S_RESET..S_JUMP;
  - opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J;
  - ALUOp codes (ADD, SUB, FUNCT);
  - ALUSrcB codes and PCSource codes.
- Sub-module mc_ctrl_out_decode: pure combinational map from state plus MemReady_1b to all control outputs.
- mc_ctrl_fsm keeps the state register, reset-hold counter, next-state logic and PCEn.

Test Plan:
- Reset with RESET_VECTOR_EN_CYCLES=1, MemReady=1 -> State_4b=0 with all outputs 0 during reset; one edge after release State=1 with MemRead=1, IRWrite=1, PCWrite=1.
- Opcode 000000, MemReady=1 -> states 1,2,7,8; ALUOp=10 in state 7; RegWrite=1 and RegDst=1 in state 8; Instr_Done pulses at cycle 4.
- Opcode 100011 with MemReady low for 2 cycles in S_MEMRD -> states 1,2,3,4,4,4,5; MemRead and IorD held at 1; lw retires at cycle 7 with MemtoReg=1.
- Opcode 000100:
  - Zero_1b=1 -> PCEn=1 and PCSource=01 in state 9.
  - Zero_1b=0 -> PCEn=0.
  - Both cases return to state 1.
- Opcode 111111 -> Illegal_Op_1b=1 in state 2, next state 1; RegWrite, MemWrite and PCEn stay 0. With MC_JUMP_EN, opcode 000010 -> state 12 with PCWrite=1 and PCSource=10.
- Reset_n_1b asserted while in S_MEMWR with MemWrite=1 -> MemWrite drops to 0 asynchronously; after release the FSM restarts at S_RESET then S_FETCH.
